// File: rtl/pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module : pack_pkg
//  Brief  : Constants and types shared by the Pack serializer and the Unpack
//           deserializer: frame geometry, sync word, FSM state type and a
//           32-bit popcount helper used for the preamble Hamming distance.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
package pack_pkg;

    localparam int SIZE_BIT_PACK   = 1976;
    localparam int SIZE_INPUT_BIT  = 1;
    localparam int SIZE_OUTPUT_BIT = 8;
    localparam int SIZE_PREAMBLE   = 32;
    localparam logic [SIZE_PREAMBLE-1:0] PREAMBLE = 32'hCF80AA31;
    localparam int LENGTH_PAYLOAD  = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_OUTPUT_BIT;
    localparam int BYTE_CNT_W      = $clog2(LENGTH_PAYLOAD);

    typedef enum logic {
        SEARCH  = 1'b0,
        COLLECT = 1'b1
    } unpack_state_t;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int k = 0; k < 32; k++) begin
            n = n + {5'd0, v[k]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module : byte_fifo
//  Brief  : Synchronous first-word-fall-through FIFO. The head entry is always
//           presented on data_o while empty_o is low. Storage, pointers and
//           occupancy are all registers, so full_o/empty_o are registered
//           flags: a pop in the same cycle does not make room for a push.
//  Ports  : clk_i, rst_i (sync, active-high), push_i/data_i (write side),
//           pop_i (consume head), data_o (head entry), full_o, empty_o.
//  Rev    : 1.0  initial release
// ============================================================================
module byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Cleared so the head reads as zero straight after reset.
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/unpack.sv
`default_nettype none
// ============================================================================
//  Module : unpack
//  Brief  : Serial-to-byte deserializer. Hunts for the 32-bit sync word in the
//           incoming bit stream, then collects the 243-byte payload MSB first
//           into a small output FIFO and returns to hunting.
//  Ports  : i_clk, i_reset (sync, active-high)
//           i_data/i_valid_input/o_ready       serial bit input handshake
//           o_data/o_last/o_valid/i_ready_output byte output handshake
//           o_locked                            high while collecting payload
//  Rev    : 1.0  initial release
// ============================================================================
module unpack
    import pack_pkg::*;
#(
    parameter int MAX_SYNC_ERRORS = 0,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_data,
    input  logic       i_valid_input,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready_output,
    output logic       o_last,
    output logic       o_locked
);

    unpack_state_t           state_q;
    logic [31:0]             shift_q;
    logic [31:0]             shift_d;
    logic [6:0]              acc_q;
    logic [2:0]              bit_cnt_q;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q;

    logic       w_accept;
    logic       w_match;
    logic       w_byte_last;
    logic       w_push;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [8:0] w_fifo_rdata;

    assign shift_d     = {shift_q[30:0], i_data};
    assign w_match     = popcount32(shift_d ^ PREAMBLE) <= 6'(MAX_SYNC_ERRORS);
    assign w_byte_last = (byte_cnt_q == BYTE_CNT_W'(LENGTH_PAYLOAD - 1));

    // The eighth bit of a byte is held off while the FIFO is full, so a
    // completed byte always has a slot to land in.
    assign o_ready  = (state_q == SEARCH) || (bit_cnt_q != 3'd7) || !w_fifo_full;
    assign w_accept = i_valid_input && o_ready;
    assign w_push   = w_accept && (state_q == COLLECT) && (bit_cnt_q == 3'd7);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= SEARCH;
            shift_q    <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else if (w_accept) begin
            case (state_q)
                SEARCH: begin
                    shift_q <= shift_d;
                    if (w_match) begin
                        state_q    <= COLLECT;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                COLLECT: begin
                    acc_q <= {acc_q[5:0], i_data};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
                        if (w_byte_last) begin
                            // Clear the window so a following frame must
                            // present a full fresh sync word.
                            state_q <= SEARCH;
                            shift_q <= '0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    byte_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .push_i  (w_push),
        .data_i  ({w_byte_last, acc_q, i_data}),
        .pop_i   (i_ready_output),
        .data_o  (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign o_valid  = !w_fifo_empty;
    assign o_data   = w_fifo_rdata[7:0];
    assign o_last   = w_fifo_rdata[8];
    assign o_locked = (state_q == COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_unpack.sv
`default_nettype none
// ============================================================================
//  Module : tb_unpack
//  Brief  : Self-checking bench for unpack. A frame-level model (sliding sync
//           window, bit-to-byte arithmetic, byte queue standing in for the
//           output buffer) predicts every output each cycle; literal checks
//           pin the model at key points.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_unpack;
    import pack_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       vin = 1'b0;
    logic       rout = 1'b1;
    logic       d0_ready, d0_valid, d0_last, d0_locked;
    logic [7:0] d0_data;
    logic       d1_ready, d1_valid, d1_last, d1_locked;
    logic [7:0] d1_data;

    unpack #(.MAX_SYNC_ERRORS(0), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid_input(vin),
        .o_ready(d0_ready), .o_data(d0_data), .o_valid(d0_valid),
        .i_ready_output(rout), .o_last(d0_last), .o_locked(d0_locked)
    );

    unpack #(.MAX_SYNC_ERRORS(1), .FIFO_DEPTH(4)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_data(din), .i_valid_input(vin),
        .o_ready(d1_ready), .o_data(d1_data), .o_valid(d1_valid),
        .i_ready_output(1'b1), .o_last(d1_last), .o_locked(d1_locked)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]  mq[$];
    bit          m_locked = 0;
    logic [31:0] m_win    = '0;
    int          m_nbit   = 0;
    int          m_byte   = 0;
    int          m_nbytes = 0;
    bit          chk_en   = 0;
    int          ro_mode  = 0;
    int          stall_left = 0;
    bit          acc_flag;
    bit          saw_stall = 0;
    int          rx_count = 0;
    logic [7:0]  rx_data [0:4095];
    bit          rx_last [0:4095];
    logic [7:0]  pl [0:242];

    function automatic int ham(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        for (int k = 0; k < 32; k++) if (a[k] != b[k]) n++;
        return n;
    endfunction

    task automatic model_bit(input logic b);
        if (!m_locked) begin
            m_win = {m_win[30:0], b};
            if (ham(m_win, PREAMBLE) == 0) begin
                m_locked = 1; m_nbit = 0; m_nbytes = 0; m_byte = 0;
            end
        end else begin
            m_byte = m_byte * 2 + int'(b);
            m_nbit++;
            if (m_nbit == 8) begin
                mq.push_back({(m_nbytes == LENGTH_PAYLOAD - 1), 8'(m_byte)});
                m_nbytes++;
                m_nbit = 0;
                m_byte = 0;
                if (m_nbytes == LENGTH_PAYLOAD) begin
                    m_locked = 0;
                    m_win    = '0;
                end
            end
        end
    endtask

    // One clock: check outputs at the falling edge, then drive the inputs for
    // the coming rising edge and advance the model to match it.
    task automatic step(input bit r, input bit v, input bit d);
        bit exp_ready;
        bit ro;
        @(negedge clk);
        exp_ready = !(m_locked && m_nbit == 7 && mq.size() == 4);
        if (chk_en) begin
            check("o_ready", 32'(d0_ready), 32'(exp_ready));
            check("o_locked", 32'(d0_locked), 32'(m_locked));
            check("o_valid", 32'(d0_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("o_data", 32'(d0_data), 32'(mq[0][7:0]));
                check("o_last", 32'(d0_last), 32'(mq[0][8]));
            end
            if (!d0_ready) saw_stall = 1;
        end
        if (stall_left > 0) begin
            ro = 0;
            stall_left--;
        end else if (ro_mode == 1) ro = 1'($urandom_range(0, 1));
        else ro = 1;
        rst = r; vin = v; din = d; rout = ro;
        acc_flag = 0;
        if (r) begin
            mq.delete();
            m_locked = 0; m_win = '0; m_nbit = 0; m_byte = 0; m_nbytes = 0;
            chk_en = 1;
        end else begin
            if (ro && mq.size() != 0) begin
                if (rx_count < 4096) begin
                    rx_data[rx_count] = d0_data;
                    rx_last[rx_count] = d0_last;
                end
                rx_count++;
                void'(mq.pop_front());
            end
            if (v && exp_ready) begin
                model_bit(d);
                acc_flag = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_bit(input logic b, input bit gap);
        int tries = 0;
        if (gap) step(0, 0, 1'($urandom_range(0, 1)));
        do begin
            step(0, 1, b);
            tries++;
        end while (!acc_flag && tries < 2000);
        if (!acc_flag) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 31; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic send_bytes(input int n, input bit gap, input int stall_at);
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) stall_left = 60;
            for (int i = 7; i >= 0; i--) send_bit(pl[b][i], gap);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bad, nlast;
        logic [31:0] w;
        logic b;

        // ---- reset state ----
        step(1, 0, 0);
        step(0, 0, 0);
        check("rst_o_valid", 32'(d0_valid), 32'd0);
        check("rst_o_locked", 32'(d0_locked), 32'd0);
        check("rst_o_data", 32'(d0_data), 32'd0);
        check("rst_o_ready", 32'(d0_ready), 32'd1);
        check("rst_o_last", 32'(d0_last), 32'd0);

        // ---- 1: counting payload, valid every other cycle ----
        for (int i = 0; i < 243; i++) pl[i] = 8'(i);
        base = rx_count;
        send_word(PREAMBLE, 1);
        send_bytes(243, 1, -1);
        idle(10);
        check("t1_count", 32'(rx_count - base), 32'd243);
        bad = 0; nlast = 0;
        for (int i = 0; i < 243; i++) begin
            if (rx_data[base + i] !== 8'(i)) bad++;
            if (rx_last[base + i]) nlast++;
        end
        check("t1_data", 32'(bad), 32'd0);
        check("t1_last_count", 32'(nlast), 32'd1);
        check("t1_last_pos", 32'(rx_last[base + 242]), 32'd1);
        check("t1_unlocked", 32'(d0_locked), 32'd0);

        // ---- 2: random noise without sync word, then a frame ----
        ro_mode = 1;
        base = rx_count;
        w = '0;
        for (int i = 0; i < 100; i++) begin
            b = 1'($urandom_range(0, 1));
            if ({w[30:0], b} == PREAMBLE) b = ~b;
            w = {w[30:0], b};
            send_bit(b, 0);
        end
        idle(2);
        check("t2_noise_no_out", 32'(rx_count - base), 32'd0);
        check("t2_noise_unlocked", 32'(d0_locked), 32'd0);
        for (int i = 0; i < 243; i++) pl[i] = 8'($urandom);
        send_word(PREAMBLE, 0);
        send_bytes(243, 0, -1);
        idle(30);
        check("t2_count", 32'(rx_count - base), 32'd243);

        // ---- 3: output stalled 60 cycles mid-payload ----
        ro_mode = 0;
        saw_stall = 0;
        base = rx_count;
        for (int i = 0; i < 243; i++) pl[i] = 8'($urandom);
        send_word(PREAMBLE, 0);
        send_bytes(243, 0, 20);
        idle(10);
        check("t3_saw_backpressure", 32'(saw_stall), 32'd1);
        check("t3_count", 32'(rx_count - base), 32'd243);
        bad = 0;
        for (int i = 0; i < 243; i++) if (rx_data[base + i] !== pl[i]) bad++;
        check("t3_data", 32'(bad), 32'd0);

        // ---- 4: sync-error tolerance ----
        step(1, 0, 0);
        send_word(32'hCF80AA30, 0);
        step(0, 0, 0);
        check("t4_tol1_locks_30", 32'(d1_locked), 32'd1);
        check("t4_tol0_rejects_30", 32'(d0_locked), 32'd0);
        step(1, 0, 0);
        send_word(32'hCF80AA32, 0);
        step(0, 0, 0);
        check("t4_tol1_rejects_32", 32'(d1_locked), 32'd0);
        check("t4_tol0_rejects_32", 32'(d0_locked), 32'd0);

        // ---- 5: reset mid-frame ----
        step(1, 0, 0);
        for (int i = 0; i < 243; i++) pl[i] = 8'($urandom);
        send_word(PREAMBLE, 0);
        send_bytes(100, 0, -1);
        step(1, 0, 0);
        step(0, 0, 0);
        check("t5_rst_o_valid", 32'(d0_valid), 32'd0);
        check("t5_rst_o_locked", 32'(d0_locked), 32'd0);
        base = rx_count;
        send_word(PREAMBLE, 0);
        send_bytes(243, 0, -1);
        idle(10);
        check("t5_count", 32'(rx_count - base), 32'd243);
        bad = 0;
        for (int i = 0; i < 243; i++) if (rx_data[base + i] !== pl[i]) bad++;
        check("t5_data", 32'(bad), 32'd0);

        // ---- 6: back-to-back frames, sync word inside payload ----
        ro_mode = 1;
        base = rx_count;
        for (int i = 0; i < 243; i++) pl[i] = 8'(i) ^ 8'h5A;
        pl[10] = 8'hCF; pl[11] = 8'h80; pl[12] = 8'hAA; pl[13] = 8'h31;
        send_word(PREAMBLE, 0);
        send_bytes(243, 0, -1);
        send_word(PREAMBLE, 0);
        send_bytes(243, 0, -1);
        idle(60);
        check("t6_count", 32'(rx_count - base), 32'd486);
        check("t6_byte13", 32'(rx_data[base + 13]), 32'h31);
        check("t6_frame2_byte0", 32'(rx_data[base + 243]), 32'h5A);
        check("t6_unlocked", 32'(d0_locked), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
